// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point radix-4 FFT datapath: IEEE-754 twiddle
// constants, sequencer state encoding and twiddle exponent helper.
package fft_pkg;

  localparam int N_POINTS = 16;
  localparam int RADIX    = 4;

  // Twiddle magnitudes: cos(pi*m/8) for m = 0..4
  localparam logic [31:0] FP_C0   = 32'h3F80_0000;
  localparam logic [31:0] FP_C1   = 32'h3F6C_835E;
  localparam logic [31:0] FP_C2   = 32'h3F35_04F3;
  localparam logic [31:0] FP_C3   = 32'h3EC3_EF15;
  localparam logic [31:0] FP_C4   = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // First-stage exponent e = (n*k) mod 16 with k = idx[3:2], n = idx[1:0]
  function automatic logic [3:0] twiddle_exp(input logic [3:0] idx);
    return {2'b00, idx[1:0]} * {2'b00, idx[3:2]};
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Combinational twiddle lookup: W16^e as IEEE-754 (re, im), optionally
// conjugated. Magnitudes come from a 5-entry table, signs from the octant.
module twiddle_rom
  import fft_pkg::*;
(
  input  logic [3:0]  e,
  input  logic        inverse,
  output logic [31:0] re,
  output logic [31:0] im
);

  logic [2:0]  oct;
  logic [2:0]  cos_sel;
  logic [2:0]  sin_sel;
  logic        cos_neg;
  logic        sin_neg;
  logic        im_neg;
  logic [31:0] cos_mag;
  logic [31:0] sin_mag;

  function automatic logic [31:0] mag(input logic [2:0] sel);
    case (sel)
      3'd0:    return FP_C0;
      3'd1:    return FP_C1;
      3'd2:    return FP_C2;
      3'd3:    return FP_C3;
      default: return FP_C4;
    endcase
  endfunction

  always_comb begin
    oct     = e[2:0];
    cos_sel = (oct > 3'd4) ? (3'd0 - oct) : oct;
    sin_sel = (oct > 3'd4) ? (oct - 3'd4) : (3'd4 - oct);
    cos_neg = (e >= 4'd5) && (e <= 4'd11);
    sin_neg = (e >= 4'd9);
    // forward emits -sin, inverse emits +sin
    im_neg  = sin_neg ^ ~inverse;
    cos_mag = mag(cos_sel);
    sin_mag = mag(sin_sel);
    // a zero magnitude never carries a sign bit
    re = {cos_neg && (cos_sel != 3'd4), cos_mag[30:0]};
    im = {im_neg  && (sin_sel != 3'd4), sin_mag[30:0]};
  end

endmodule

// File: rtl/twiddle_sequencer.sv
// Streams 32 twiddle operands per 16-point frame (stage 0 then stage 1)
// to the complex multiplier over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; busy low
// RUN   | presenting twiddles, advancing on each handshake
// DONE  | one cycle after the final handshake; frame_done high
module twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inverse,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] tw_real,
  output logic [DATA_W-1:0] tw_im,
  output logic [3:0]        tw_index,
  output logic              tw_stage,
  output logic              busy,
  output logic              frame_done
);

  localparam logic LAST_STAGE = 1'(NUM_STAGES - 1);

  seq_state_t  state, state_nxt;
  logic [3:0]  idx_nxt;
  logic        stg_nxt;
  logic        inv_q, inv_nxt;
  logic        vld_nxt;
  logic        load;
  logic [3:0]  rom_e;
  logic [31:0] rom_re, rom_im;

  twiddle_rom u_rom (
    .e       (rom_e),
    .inverse (inv_nxt),
    .re      (rom_re),
    .im      (rom_im)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = tw_index;
    stg_nxt   = tw_stage;
    inv_nxt   = inv_q;
    vld_nxt   = out_valid;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          inv_nxt   = inverse;
          idx_nxt   = 4'd0;
          stg_nxt   = 1'b0;
          vld_nxt   = 1'b1;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (out_valid && out_ready) begin
          if (tw_index != 4'd15) begin
            idx_nxt = tw_index + 4'd1;
            load    = 1'b1;
          end else if (tw_stage != LAST_STAGE) begin
            stg_nxt = tw_stage + 1'b1;
            idx_nxt = 4'd0;
            load    = 1'b1;
          end else begin
            state_nxt = DONE;
            vld_nxt   = 1'b0;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    rom_e = twiddle_exp(idx_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      inv_q     <= 1'b0;
      out_valid <= 1'b0;
      tw_index  <= 4'd0;
      tw_stage  <= 1'b0;
      tw_real   <= '0;
      tw_im     <= '0;
    end else begin
      state     <= state_nxt;
      inv_q     <= inv_nxt;
      out_valid <= vld_nxt;
      tw_index  <= idx_nxt;
      tw_stage  <= stg_nxt;
      if (load) begin
        // later stages of a 16-point radix-4 frame need no rotation
        tw_real <= stg_nxt ? FP_ONE  : rom_re;
        tw_im   <= stg_nxt ? FP_ZERO : rom_im;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule
